trace_packer: RTL and testbench

TRACE_PACKER -- requirements
Module: trace_packer

---
 rtl/trace_pkg.sv | 32 +++
 rtl/trace_queue.sv | 35 +++
 rtl/trace_packer.sv | 101 ++++++++++
 tb/tb_trace_packer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: record type codes, ch1 field positions, queue entry type and defaults shared by the trace packer.
package trace_pkg;
    localparam logic [1:0] REC_COMMIT = 2'b10;
    localparam logic [1:0] REC_SYNC   = 2'b11;
    localparam int TYPE_LSB  = 62;
    localparam int SEQ_LSB   = 56;
    localparam int REG_LSB   = 48;
    localparam int DELTA_LSB = 32;
    localparam int DEF_QDEPTH    = 4;
    localparam int DEF_STALL_THR = 3;
    typedef struct packed {
        logic [1:0]  en;
        logic [63:0] ch1;
        logic [63:0] ch0;
    } entry_t;
    function automatic logic [63:0] commit_ch1(input logic [5:0] seq, input logic [4:0] rd,
                                               input logic [15:0] delta, input logic [31:0] data);
        logic [63:0] r;
        r = {32'd0, data};
        r[TYPE_LSB +: 2]   = REC_COMMIT;
        r[SEQ_LSB +: 6]    = seq;
        r[REG_LSB +: 5]    = rd;
        r[DELTA_LSB +: 16] = delta;
        return r;
    endfunction
    function automatic logic [63:0] sync_ch1(input logic [31:0] cyc);
        logic [63:0] r;
        r = {32'd0, cyc};
        r[TYPE_LSB +: 2] = REC_SYNC;
        return r;
    endfunction
endpackage

// File: rtl/trace_queue.sv
// trace_queue: power-of-two synchronous FIFO of trace entries with push, pop and occupancy count.
module trace_queue #(
    parameter int DEPTH = 4,
    parameter int W = 130
) (
    input  logic                   clk_clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           dout_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    assign dout_o  = mem_q[rd_q];
    assign count_o = count_q;
    always_ff @(posedge clk_clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push_i);
            rd_q    <= rd_q + AW'(pop_i);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
endmodule

// File: rtl/trace_packer.sv
// trace_packer: turns retired instructions and enable-rise sync markers into two-channel trace records,
// buffered in a small queue with backpressure, stall request and drop accounting.
module trace_packer
    import trace_pkg::*;
#(
    parameter int QDEPTH = DEF_QDEPTH,
    parameter int STALL_THR = DEF_STALL_THR
) (
    input  logic         clk_clk,
    input  logic         reset_n,
    input  logic         trace_enable,
    input  logic         commit_valid,
    input  logic [31:0]  commit_pc,
    input  logic [31:0]  commit_inst,
    input  logic         wb_en,
    input  logic [4:0]   wb_reg,
    input  logic [31:0]  wb_data,
    input  logic         full,
    output logic [127:0] trace_data,
    output logic [1:0]   trace_en,
    output logic         stall_req,
    output logic [15:0]  drop_cnt,
    output logic         overflow
);
    localparam int CW = $clog2(QDEPTH) + 1;
    logic          enable_q, first_q, ovf_q, stall_q;
    logic [31:0]   cyc_q;
    logic [5:0]    seq_q;
    logic [15:0]   delta_q, drop_q, rec_delta;
    logic [1:0]    en_q;
    logic [127:0]  data_q;
    logic          sync, commit, push_req, empty, q_full, bypass, q_push, q_pop, accept;
    logic [CW-1:0] count, count_d;
    entry_t        rec, head;
    always_comb begin
        sync      = trace_enable & ~enable_q;
        commit    = commit_valid & enable_q;
        push_req  = sync | commit;
        rec_delta = first_q ? 16'd0 : delta_q;
        rec.ch0   = sync ? 64'd0 : {commit_pc, commit_inst};
        rec.ch1   = sync ? sync_ch1(cyc_q) : commit_ch1(seq_q, wb_reg, rec_delta, wb_data);
        rec.en    = sync ? 2'b10 : {wb_en | (rec_delta == 16'hFFFF), 1'b1};
        empty     = count == '0;
        q_full    = count == CW'(QDEPTH);
        q_pop     = ~empty & ~full;
        // An empty queue hands the new record straight to the output register for 1-cycle latency.
        bypass    = empty & ~full & push_req;
        q_push    = push_req & ~bypass & (~q_full | q_pop);
        accept    = bypass | q_push;
        count_d   = count + CW'(q_push) - CW'(q_pop);
    end
    trace_queue #(.DEPTH(QDEPTH), .W($bits(entry_t))) u_queue (
        .clk_clk (clk_clk),
        .reset_n (reset_n),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .din_i   (rec),
        .dout_o  (head),
        .count_o (count)
    );
    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q <= 1'b0;
            first_q  <= 1'b1;
            cyc_q    <= '0;
            seq_q    <= '0;
            delta_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            stall_q  <= 1'b0;
            en_q     <= '0;
            data_q   <= '0;
        end else begin
            enable_q <= trace_enable;
            cyc_q    <= cyc_q + 32'd1;
            en_q     <= q_pop ? head.en : bypass ? rec.en : 2'b00;
            if (q_pop | bypass) data_q <= q_pop ? {head.ch1, head.ch0} : {rec.ch1, rec.ch0};
            stall_q  <= count_d >= CW'(STALL_THR);
            if (sync) begin
                seq_q   <= '0;
                delta_q <= '0;
                first_q <= 1'b1;
            end else if (commit & accept) begin
                seq_q   <= seq_q + 6'd1;
                delta_q <= 16'd1;
                first_q <= 1'b0;
            end else begin
                delta_q <= delta_q + {15'd0, delta_q != 16'hFFFF};
            end
            if (commit & ~accept) begin
                drop_q <= drop_q + {15'd0, drop_q != 16'hFFFF};
                ovf_q  <= 1'b1;
            end
        end
    end
    assign trace_data = data_q;
    assign trace_en   = en_q;
    assign stall_req  = stall_q;
    assign drop_cnt   = drop_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_trace_packer.sv
// tb_trace_packer: directed stimulus pushes hand-computed records into a scoreboard; a negedge monitor
// pops and compares every strobe, including its arrival cycle where the latency is fixed.
module tb_trace_packer;
    logic         clk_clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         trace_enable = 1'b0;
    logic         commit_valid = 1'b0;
    logic [31:0]  commit_pc = '0;
    logic [31:0]  commit_inst = '0;
    logic         wb_en = 1'b0;
    logic [4:0]   wb_reg = '0;
    logic [31:0]  wb_data = '0;
    logic         full = 1'b0;
    logic [127:0] trace_data;
    logic [1:0]   trace_en;
    logic         stall_req;
    logic [15:0]  drop_cnt;
    logic         overflow;
    int checks = 0;
    int errors = 0;
    int cyc_tb = 0;
    typedef struct {
        logic [1:0]   en;
        logic [127:0] d;
        int           at;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    trace_packer #(.QDEPTH(4), .STALL_THR(3)) dut (
        .clk_clk      (clk_clk),
        .reset_n      (reset_n),
        .trace_enable (trace_enable),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .wb_en        (wb_en),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .full         (full),
        .trace_data   (trace_data),
        .trace_en     (trace_en),
        .stall_req    (stall_req),
        .drop_cnt     (drop_cnt),
        .overflow     (overflow)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc_tb <= cyc_tb + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic expect_rec(input logic [1:0] en, input logic [127:0] d, input int at);
        exp_t e;
        e.en = en;
        e.d  = d;
        e.at = at;
        sb.push_back(e);
    endtask

    // mode 0: output on the next cycle, 1: output later from the queue, 2: no output expected
    task automatic commit(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                          input logic [4:0] rd, input logic [31:0] d, input logic [5:0] seq,
                          input logic [15:0] delta, input logic [1:0] en, input int mode);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_inst  = inst;
        wb_en        = we;
        wb_reg       = rd;
        wb_data      = d;
        if (mode != 2)
            expect_rec(en, {2'b10, seq, 3'b000, rd, delta, d, pc, inst}, mode == 0 ? cyc_tb + 1 : -1);
        step();
        commit_valid = 1'b0;
        wb_en        = 1'b0;
    endtask

    always @(negedge clk_clk) begin
        if (trace_en !== 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got en=%b data=%h expected no strobe", trace_en, trace_data);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_en", 128'(trace_en), 128'(mon_e.en));
                check("record", trace_data, mon_e.d);
                if (mon_e.at >= 0) check("latency_cycle", 128'(cyc_tb), 128'(mon_e.at));
            end
        end
    end

    initial begin
        step(3);
        check("rst_trace_en", 128'(trace_en), 128'(0));
        check("rst_trace_data", trace_data, 128'(0));
        check("rst_stall", 128'(stall_req), 128'(0));
        check("rst_drop_cnt", 128'(drop_cnt), 128'(0));
        check("rst_overflow", 128'(overflow), 128'(0));
        reset_n = 1'b1;
        step(100);
        trace_enable = 1'b1;
        expect_rec(2'b10, {2'b11, 30'd0, 32'd100, 64'd0}, cyc_tb + 1);
        step();
        commit(32'hBFC00000, 32'h24020005, 1'b1, 5'd2, 32'd5, 6'd0, 16'd0, 2'b11, 0);
        step(2);
        commit(32'hBFC00004, 32'h3C011234, 1'b0, 5'd7, 32'h1234, 6'd1, 16'd3, 2'b01, 0);
        commit(32'hBFC00008, 32'h8C430010, 1'b1, 5'd3, 32'hDEADBEEF, 6'd2, 16'd1, 2'b11, 0);
        step(3);
        full = 1'b1;
        commit(32'h80000000, 32'h00000001, 1'b1, 5'd4, 32'h11, 6'd3, 16'd4, 2'b11, 1);
        commit(32'h80000004, 32'h00000002, 1'b0, 5'd5, 32'h22, 6'd4, 16'd1, 2'b01, 1);
        check("stall_count2", 128'(stall_req), 128'(0));
        commit(32'h80000008, 32'h00000003, 1'b1, 5'd6, 32'h33, 6'd5, 16'd1, 2'b11, 1);
        check("stall_count3", 128'(stall_req), 128'(1));
        commit(32'h8000000C, 32'h00000004, 1'b0, 5'd8, 32'h44, 6'd6, 16'd1, 2'b01, 1);
        check("drop_before_full", 128'(drop_cnt), 128'(0));
        commit(32'h80000010, 32'h00000005, 1'b1, 5'd9, 32'h55, 6'd0, 16'd0, 2'b00, 2);
        check("drop_cnt_one", 128'(drop_cnt), 128'(1));
        check("overflow_set", 128'(overflow), 128'(1));
        check("stall_full", 128'(stall_req), 128'(1));
        full = 1'b0;
        step();
        check("stall_drain3", 128'(stall_req), 128'(1));
        step();
        check("stall_drain2", 128'(stall_req), 128'(0));
        step(2);
        commit(32'h90000000, 32'h0000ABCD, 1'b1, 5'd10, 32'h77, 6'd7, 16'd6, 2'b11, 0);
        for (int i = 0; i < 57; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            commit(32'h1000 + 4 * iv, iv, iv[0], iv[4:0], iv, 6'(8 + i), 16'd1, {iv[0], 1'b1}, 0);
        end
        step(70000);
        commit(32'hA0000000, 32'h0000FFFF, 1'b0, 5'd11, 32'h99, 6'd1, 16'hFFFF, 2'b11, 0);
        check("overflow_sticky", 128'(overflow), 128'(1));
        full = 1'b1;
        commit(32'hB0000000, 32'h1, 1'b1, 5'd1, 32'h1, 6'd2, 16'd1, 2'b11, 2);
        commit(32'hB0000004, 32'h2, 1'b1, 5'd1, 32'h2, 6'd3, 16'd1, 2'b11, 2);
        commit(32'hB0000008, 32'h3, 1'b1, 5'd1, 32'h3, 6'd4, 16'd1, 2'b11, 2);
        check("stall_three_queued", 128'(stall_req), 128'(1));
        check("drop_before_reset", 128'(drop_cnt), 128'(1));
        reset_n = 1'b0;
        trace_enable = 1'b0;
        full = 1'b0;
        #1;
        check("midrst_trace_en", 128'(trace_en), 128'(0));
        check("midrst_trace_data", trace_data, 128'(0));
        check("midrst_stall", 128'(stall_req), 128'(0));
        check("midrst_drop_cnt", 128'(drop_cnt), 128'(0));
        check("midrst_overflow", 128'(overflow), 128'(0));
        step(2);
        reset_n = 1'b1;
        step(10);
        check("post_rst_stall", 128'(stall_req), 128'(0));
        trace_enable = 1'b1;
        reset_n = 1'b0;
        step(2);
        expect_rec(2'b10, {2'b11, 30'd0, 32'd0, 64'd0}, cyc_tb + 1);
        reset_n = 1'b1;
        step(4);
        check("data_holds", trace_data, {2'b11, 30'd0, 32'd0, 64'd0});
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
